ctrl_seq_unit: RTL and testbench

Parametrised successor to the 4-bit processor's control unit: program memory, program counter and instruction sequencer with a configurable data/bus width, program depth and return stack. Programs are written sequentially in load mode and executed in run mode. Conditional branches test the shared data bus. Sits between the program-load interface and the datapath (accumulator/ALU), which consumes `instr` and shares `bus`.

---
 rtl/ctrl_pkg.sv | 28 ++
 rtl/ctrl_ret_stack.sv | 46 ++++
 rtl/ctrl_seq_unit.sv | 173 +++++++++++++++++
 tb/tb_ctrl_seq_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared FSM state, instruction field positions and opcode encodings for ctrl_seq_unit.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } ctrl_state_e;

  // Field positions are measured down from the instruction width IW.
  localparam int SYS_OFS   = 1;
  localparam int OP_HI_OFS = 2;
  localparam int OP_LO_OFS = 3;
  localparam int J_OFS     = 4;

  // op values with sys=0, j=0
  localparam logic [1:0] OP_LDI  = 2'b01;
  // op values with sys=0, j=1
  localparam logic [1:0] OP_JMP  = 2'b00;
  localparam logic [1:0] OP_JNZ  = 2'b01;
  localparam logic [1:0] OP_JZ   = 2'b10;
  localparam logic [1:0] OP_CALL = 2'b11;
  // op values with sys=1
  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RET  = 2'b01;

endpackage

// File: rtl/ctrl_ret_stack.sv
// Return-address LIFO; push on full and pop on empty leave the stack untouched,
// the caller raises the error flag.
module ctrl_ret_stack #(
  parameter int AW = 4,
  parameter int SD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] push_dat_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW-1:0] top_o
);

  localparam int SPW = $clog2(SD + 1);
  localparam int IXW = (SD > 1) ? $clog2(SD) : 1;

  logic [AW-1:0]  ent_q [SD];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_m1;

  assign full_o  = (sp_q == SPW'(SD));
  assign empty_o = (sp_q == '0);
  assign sp_m1   = sp_q - SPW'(1);
  assign top_o   = ent_q[sp_m1[IXW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sp_q <= '0;
    end else if (push_i && !full_o) begin
      sp_q <= sp_q + SPW'(1);
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      ent_q[sp_q[IXW-1:0]] <= push_dat_i;
    end
  end

endmodule

// File: rtl/ctrl_seq_unit.sv
// Program memory, PC and two-cycle FETCH/EXEC sequencer; bus driven only during an LDI EXEC.
// Return stack for CALL/RET is compiled in with CTRL_RET_STACK_EN.
module ctrl_seq_unit
  import ctrl_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 4,
  parameter int SD = 4,
  localparam int IW = DW + 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          state,
  input  logic          load,
  input  logic [IW-1:0] instr_i,
  output logic [IW-1:0] instr,
  output logic          instr_vld,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          stk_err,
  inout  wire  [DW-1:0] bus
);

  ctrl_state_e   fsm_q;
  logic [IW-1:0] instr_q;
  logic          instr_vld_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic [AW-1:0] wr_ptr_q;
  logic          halted_q;
  logic [IW-1:0] mem [2**AW];

  logic          sys;
  logic [1:0]    op;
  logic          j;
  logic [AW-1:0] tgt;
  logic          in_exec;
  logic          run_exit;
  logic          is_ret;
  logic          is_halt;
  logic          ldi_drv;
  logic          bus_zero;

  assign sys = instr_q[IW-SYS_OFS];
  assign op  = instr_q[IW-OP_HI_OFS:IW-OP_LO_OFS];
  assign j   = instr_q[IW-J_OFS];
  assign tgt = instr_q[AW-1:0];

  assign in_exec  = (fsm_q == ST_EXEC);
  assign run_exit = (fsm_q != ST_IDLE) && !state;
  assign is_ret   = sys && (op == OP_RET);
  assign is_halt  = sys && (op == OP_HALT);
  assign ldi_drv  = in_exec && !sys && !j && (op == OP_LDI);
  assign bus_zero = (bus == '0);
  assign bus      = ldi_drv ? instr_q[DW-1:0] : {DW{1'bz}};

`ifdef CTRL_RET_STACK_EN
  logic          stk_push;
  logic          stk_pop;
  logic          stk_full;
  logic          stk_empty;
  logic [AW-1:0] stk_top;
  logic          stk_err_q;

  // pc_q already points past the CALL, so it is the return address.
  assign stk_push = in_exec && state && !sys && j && (op == OP_CALL);
  assign stk_pop  = in_exec && state && is_ret;

  ctrl_ret_stack #(
    .AW(AW),
    .SD(SD)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (run_exit),
    .push_i    (stk_push),
    .pop_i     (stk_pop),
    .push_dat_i(pc_q),
    .full_o    (stk_full),
    .empty_o   (stk_empty),
    .top_o     (stk_top)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stk_err_q <= 1'b0;
    end else if ((stk_push && stk_full) || (stk_pop && stk_empty)) begin
      stk_err_q <= 1'b1;
    end
  end

  assign stk_err = stk_err_q;
`else
  logic [32:0] unused_cfg;
  assign unused_cfg = {is_ret, SD};
  assign stk_err    = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    if (!sys && j) begin
      case (op)
        OP_JMP:  pc_d = tgt;
        OP_JNZ:  if (!bus_zero) pc_d = tgt;
        OP_JZ:   if (bus_zero) pc_d = tgt;
        OP_CALL: pc_d = tgt;
        default: pc_d = pc_q;
      endcase
    end
`ifdef CTRL_RET_STACK_EN
    else if (is_ret && !stk_empty) begin
      pc_d = stk_top;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      instr_q     <= '0;
      instr_vld_q <= 1'b0;
      pc_q        <= '0;
      wr_ptr_q    <= '0;
      halted_q    <= 1'b0;
    end else if (run_exit) begin
      fsm_q       <= ST_IDLE;
      instr_vld_q <= 1'b0;
      wr_ptr_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (load) wr_ptr_q <= wr_ptr_q + AW'(1);
          if (state) begin
            fsm_q <= ST_FETCH;
            pc_q  <= '0;
          end
        end
        ST_FETCH: begin
          instr_q     <= mem[pc_q];
          pc_q        <= pc_q + AW'(1);
          instr_vld_q <= 1'b1;
          fsm_q       <= ST_EXEC;
        end
        ST_EXEC: begin
          instr_vld_q <= 1'b0;
          pc_q        <= pc_d;
          if (is_halt) begin
            fsm_q    <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            fsm_q <= ST_FETCH;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Program storage carries no reset; contents survive rst and run/idle changes.
  always_ff @(posedge clk) begin
    if (!rst && (fsm_q == ST_IDLE) && load) begin
      mem[wr_ptr_q] <= instr_i;
    end
  end

  assign instr     = instr_q;
  assign instr_vld = instr_vld_q;
  assign pc        = pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Directed and random programs checked against an instruction-level model of the sequencer.
module tb_ctrl_seq_unit;

  localparam int TB_SD = 4;
`ifdef CTRL_RET_STACK_EN
  localparam logic [3:0] RET_PC  = 4'd3;
  localparam logic       EXP_ERR = 1'b1;
`else
  localparam logic [3:0] RET_PC  = 4'd9;
  localparam logic       EXP_ERR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       state;
  logic       load;
  logic [7:0] instr_i;
  logic [7:0] instr;
  logic       instr_vld;
  logic [3:0] pc;
  logic       halted;
  logic       stk_err;
  wire  [3:0] bus;

  logic       ext_en;
  logic [3:0] ext_val;
  assign bus = ext_en ? ext_val : 4'bz;

  ctrl_seq_unit #(.DW(4), .AW(4), .SD(TB_SD)) dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .load     (load),
    .instr_i  (instr_i),
    .instr    (instr),
    .instr_vld(instr_vld),
    .pc       (pc),
    .halted   (halted),
    .stk_err  (stk_err),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [7:0] m_mem [16];
  logic [3:0] m_wr;
  logic [3:0] m_pc;
  logic [3:0] m_stk [$];
  logic       m_halt;
  logic       m_err;
  logic [7:0] m_last;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; state = 1'b0; load = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_wr = 4'd0; m_pc = 4'd0; m_halt = 1'b0; m_err = 1'b0; m_last = 8'h00;
    m_stk.delete();
  endtask

  task automatic load_word(input logic [7:0] w, input logic go);
    load = 1'b1; instr_i = w; state = go;
    @(posedge clk); #1;
    load = 1'b0;
    m_mem[m_wr] = w;
    m_wr = m_wr + 4'd1;
    if (go) m_pc = 4'd0;
  endtask

  task automatic start_run();
    state = 1'b1;
    @(posedge clk); #1;
    m_pc = 4'd0;
  endtask

  task automatic stop_run();
    state = 1'b0;
    @(posedge clk); #1;
    m_wr = 4'd0; m_halt = 1'b0;
    m_stk.delete();
    chk("idle_vld", 16'(instr_vld), 16'(0));
    chk("idle_halted", 16'(halted), 16'(m_halt));
  endtask

  // One instruction: FETCH cycle, then EXEC cycle. bf >= 0 forces the external bus value.
  task automatic step(input int bf);
    logic [7:0] w;
    logic [3:0] b, t;
    logic [1:0] op;
    logic       sys, j, ldi;
    w   = m_mem[m_pc];
    m_pc = m_pc + 4'd1;
    sys = w[7]; op = w[6:5]; j = w[4]; t = w[3:0];
    ldi = !sys && !j && (op == 2'd1);
    if (ldi) begin
      ext_en = 1'b0;
      b = t;
    end else begin
      if (bf >= 0) b = 4'(bf);
      else if ($urandom_range(1, 0) == 0) b = 4'd0;
      else b = 4'($urandom_range(15, 0));
      ext_en = 1'b1; ext_val = b;
    end
    @(posedge clk); #1;
    chk("exec_instr", 16'(instr), 16'(w));
    chk("exec_pc", 16'(pc), 16'(m_pc));
    chk("exec_vld", 16'(instr_vld), 16'(1));
    chk("exec_bus", 16'(bus), 16'(b));
    if (!sys && j) begin
      case (op)
        2'd0: m_pc = t;
        2'd1: if (b != 4'd0) m_pc = t;
        2'd2: if (b == 4'd0) m_pc = t;
        default: begin
`ifdef CTRL_RET_STACK_EN
          if (m_stk.size() < TB_SD) m_stk.push_back(m_pc);
          else m_err = 1'b1;
`endif
          m_pc = t;
        end
      endcase
    end else if (sys && op == 2'd0) begin
      m_halt = 1'b1;
    end else if (sys && op == 2'd1) begin
`ifdef CTRL_RET_STACK_EN
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_err = 1'b1;
`endif
    end
    m_last = w;
    @(posedge clk); #1;
    ext_en = 1'b1; ext_val = 4'($urandom_range(15, 0));
    #1;
    chk("post_bus", 16'(bus), 16'(ext_val));
    chk("post_pc", 16'(pc), 16'(m_pc));
    chk("post_halted", 16'(halted), 16'(m_halt));
    chk("post_vld", 16'(instr_vld), 16'(0));
    chk("post_stk_err", 16'(stk_err), 16'(m_err));
  endtask

  task automatic hold_check();
    repeat (2) @(posedge clk);
    #1;
    chk("hold_pc", 16'(pc), 16'(m_pc));
    chk("hold_instr", 16'(instr), 16'(m_last));
    chk("hold_halted", 16'(halted), 16'(1));
    chk("hold_vld", 16'(instr_vld), 16'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog [16];
    n_chk = 0; n_fail = 0;
    rst = 1'b0; state = 1'b0; load = 1'b0; instr_i = 8'h00;
    ext_en = 1'b1; ext_val = 4'h5;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;

    do_reset();
    chk("rst_instr", 16'(instr), 16'(0));
    chk("rst_vld", 16'(instr_vld), 16'(0));
    chk("rst_pc", 16'(pc), 16'(0));
    chk("rst_halted", 16'(halted), 16'(0));
    chk("rst_stk_err", 16'(stk_err), 16'(0));
    chk("rst_bus_free", 16'(bus), 16'(4'h5));

    // Sequential program with LDI and HALT
    load_word(8'h29, 1'b0); load_word(8'h42, 1'b0);
    load_word(8'h0C, 1'b0); load_word(8'h80, 1'b0);
    start_run();
    repeat (4) step(-1);
    chk("halt_pc", 16'(pc), 16'(4));
    hold_check();
    stop_run();

    // JNZ taken then not taken; LDI drives A only in its EXEC
    load_word(8'hC0, 1'b0); load_word(8'h2A, 1'b0); load_word(8'hC0, 1'b0);
    load_word(8'hC0, 1'b0); load_word(8'hC0, 1'b0); load_word(8'h33, 1'b0);
    load_word(8'h80, 1'b0);
    start_run();
    repeat (5) step(-1);
    step(1);
    chk("jnz_taken_pc", 16'(pc), 16'(3));
    repeat (2) step(-1);
    step(0);
    chk("jnz_fall_pc", 16'(pc), 16'(6));
    step(-1);
    hold_check();
    stop_run();

    // CALL to 8, RET back to 3
    for (int i = 0; i < 16; i++) begin
      case (i)
        2:       load_word(8'h78, 1'b0);
        3:       load_word(8'h80, 1'b0);
        8:       load_word(8'hA0, 1'b0);
        default: load_word(8'hC0, 1'b0);
      endcase
    end
    start_run();
    repeat (3) step(-1);
    chk("call_pc", 16'(pc), 16'(8));
    step(-1);
    chk("ret_pc", 16'(pc), 16'(RET_PC));
    for (int s = 0; s < 30 && !m_halt; s++) step(-1);
    stop_run();

    // SD+1 nested calls overflow the stack
    load_word(8'h71, 1'b0); load_word(8'h72, 1'b0); load_word(8'h73, 1'b0);
    load_word(8'h74, 1'b0); load_word(8'h75, 1'b0); load_word(8'h80, 1'b0);
    start_run();
    repeat (6) step(-1);
    chk("ovf_err", 16'(stk_err), 16'(EXP_ERR));
    hold_check();
    stop_run();

    // RET on an empty stack falls through
    do_reset();
    load_word(8'hA0, 1'b0); load_word(8'h80, 1'b0);
    start_run();
    step(-1);
    chk("unf_pc", 16'(pc), 16'(1));
    chk("unf_err", 16'(stk_err), 16'(EXP_ERR));
    step(-1);
    stop_run();

    // Reset mid-load restarts writes at address 0; last load also starts the run
    load_word(8'h11, 1'b0); load_word(8'h22, 1'b0); load_word(8'h33, 1'b0);
    do_reset();
    load_word(8'h80, 1'b1);
    step(-1);
    chk("rstload_instr", 16'(instr), 16'(8'h80));
    chk("rstload_halted", 16'(halted), 16'(1));
    hold_check();
    stop_run();

    // Random programs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(255, 0));
      for (int i = 0; i < 16; i++) load_word(prog[i], (i == 15) ? 1'b1 : 1'b0);
      for (int s = 0; s < 60 && !m_halt; s++) step(-1);
      if (m_halt) hold_check();
      stop_run();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
